// File: rtl/booth_product_accumulator.sv
// Booth product accumulator: sums a burst of LEN signed products over valid/ready.
// Optional saturating arithmetic is enabled by defining BOOTH_ACC_SAT_EN; the default build wraps.
module booth_product_accumulator #(
  parameter int unsigned PROD_W = 8,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic [PROD_W-1:0] product,
  input  logic              p_valid,
  output logic              p_ready,
  output logic [ACC_W-1:0]  acc,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ACC_W-1:0]   acc_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   sum_res;
  logic               xfer;

  assign prod_ext = ACC_W'(signed'(product));
  assign xfer     = p_valid & p_ready;

`ifdef BOOTH_ACC_SAT_EN
  logic [ACC_W:0]     sum;
  logic               sum_ovf;
  logic               ovf_q;
  logic               ovf_nxt;

  // One extra bit exposes the true sign; disagreement with bit ACC_W-1 means overflow
  assign sum     = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};
  assign sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];
  assign sum_res = !sum_ovf ? sum[ACC_W-1:0] :
                   (sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}});
  assign ovf     = ovf_q;
`else
  // Modulo-2**ACC_W accumulation; no overflow tracking is built
  assign sum_res = acc + prod_ext;
  assign ovf     = 1'b0;
`endif

  // Next-state and datapath update
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
`ifdef BOOTH_ACC_SAT_EN
    ovf_nxt   = ovf_q;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          acc_nxt = '0;
`ifdef BOOTH_ACC_SAT_EN
          ovf_nxt = 1'b0;
`endif
          if (len != '0) begin
            cnt_nxt   = len;
            state_nxt = S_ACCUM;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_ACCUM: begin
        if (xfer) begin
          acc_nxt = sum_res;
          cnt_nxt = cnt - CNT_W'(1);
`ifdef BOOTH_ACC_SAT_EN
          ovf_nxt = ovf_q | sum_ovf;
`endif
          if (cnt == CNT_W'(1)) begin
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered Moore decodes of the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      acc     <= '0;
      cnt     <= '0;
      p_ready <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      cnt     <= cnt_nxt;
      p_ready <= (state_nxt == S_ACCUM);
      busy    <= (state_nxt != S_IDLE);
      done    <= (state_nxt == S_DONE);
    end
  end

`ifdef BOOTH_ACC_SAT_EN
  // Sticky overflow flag, cleared by an accepted START
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Directed bench for booth_product_accumulator: one 16-bit and one 8-bit accumulator share stimulus.
module tb_booth_product_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] len;
  logic [7:0] product;
  logic       p_valid;

  logic        p_ready16, busy16, done16, ovf16;
  logic [15:0] acc16;
  logic        p_ready8, busy8, done8, ovf8;
  logic [7:0]  acc8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_product_accumulator u_dut16 (
    .clk(clk), .rst(rst), .start(start), .len(len), .product(product),
    .p_valid(p_valid), .p_ready(p_ready16), .acc(acc16), .busy(busy16),
    .done(done16), .ovf(ovf16)
  );

  booth_product_accumulator #(.ACC_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .len(len), .product(product),
    .p_valid(p_valid), .p_ready(p_ready8), .acc(acc8), .busy(busy8),
    .done(done8), .ovf(ovf8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Checks both instances; a16/a8 are the expected signed sums for each width
  task automatic chk_all(input string tag, input int a16, input int a8,
                         input logic rdy, input logic bsy, input logic dn, input logic ov8);
    chk({tag, ".acc16"},   32'(signed'(acc16)), 32'(a16));
    chk({tag, ".acc8"},    32'(signed'(acc8)),  32'(a8));
    chk({tag, ".ready16"}, 32'(p_ready16), 32'(rdy));
    chk({tag, ".ready8"},  32'(p_ready8),  32'(rdy));
    chk({tag, ".busy16"},  32'(busy16), 32'(bsy));
    chk({tag, ".busy8"},   32'(busy8),  32'(bsy));
    chk({tag, ".done16"},  32'(done16), 32'(dn));
    chk({tag, ".done8"},   32'(done8),  32'(dn));
    chk({tag, ".ovf16"},   32'(ovf16), 32'(0));
    chk({tag, ".ovf8"},    32'(ovf8),  32'(ov8));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = 4'd0; product = 8'd0; p_valid = 1'b0;
    tick(); tick();
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Reset in the middle of a burst
    start = 1'b1; len = 4'd4;
    tick();
    start = 1'b0;
    chk_all("rb_start", 0, 0, 1, 1, 0, 0);
    p_valid = 1'b1; product = 8'd3;
    tick();
    product = 8'd4;
    tick();
    chk_all("rb_two", 7, 7, 1, 1, 0, 0);
    p_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_all("rb_async", 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    tick(); tick();
    chk_all("rb_after", 0, 0, 0, 0, 0, 0);

    // Basic back-to-back burst: 6, -8, 15
    start = 1'b1; len = 4'd3;
    tick();
    start = 1'b0;
    chk_all("b_start", 0, 0, 1, 1, 0, 0);
    p_valid = 1'b1; product = 8'd6;
    tick();
    chk_all("b_p1", 6, 6, 1, 1, 0, 0);
    product = -8'sd8;
    tick();
    chk_all("b_p2", -2, -2, 1, 1, 0, 0);
    product = 8'd15;
    tick();
    chk_all("b_done", 13, 13, 0, 1, 1, 0);
    product = 8'd5;
    tick();
    chk_all("b_idle", 13, 13, 0, 0, 0, 0);

    // P_VALID in IDLE is ignored and ACC holds
    tick(); tick();
    chk_all("ign_idle", 13, 13, 0, 0, 0, 0);
    p_valid = 1'b0;

    // Stalled burst of two -49 products; START held high in ACCUM and DONE is ignored
    start = 1'b1; len = 4'd2;
    tick();
    len = 4'd5;
    product = -8'sd49;
    tick(); tick(); tick();
    chk_all("s_gap1", 0, 0, 1, 1, 0, 0);
    p_valid = 1'b1;
    tick();
    chk_all("s_p1", -49, -49, 1, 1, 0, 0);
    p_valid = 1'b0;
    tick(); tick(); tick();
    chk_all("s_gap2", -49, -49, 1, 1, 0, 0);
    p_valid = 1'b1;
    tick();
    chk_all("s_done", -98, -98, 0, 1, 1, 0);
    tick();
    start = 1'b0; p_valid = 1'b0;
    chk_all("s_idle", -98, -98, 0, 0, 0, 0);

    // Empty burst
    start = 1'b1; len = 4'd0;
    tick();
    start = 1'b0;
    chk_all("e_done", 0, 0, 0, 1, 1, 0);
    tick();
    chk_all("e_idle", 0, 0, 0, 0, 0, 0);

    // Overflow at 8 bits: 100, 100, -64 (16-bit instance sees 100, 200, 136)
    start = 1'b1; len = 4'd3;
    tick();
    start = 1'b0;
    p_valid = 1'b1; product = 8'd100;
    tick();
    chk_all("o_p1", 100, 100, 1, 1, 0, 0);
    tick();
`ifdef BOOTH_ACC_SAT_EN
    chk_all("o_p2", 200, 127, 1, 1, 0, 1);
`else
    chk_all("o_p2", 200, -56, 1, 1, 0, 0);
`endif
    product = -8'sd64;
    tick();
`ifdef BOOTH_ACC_SAT_EN
    chk_all("o_done", 136, 63, 0, 1, 1, 1);
`else
    chk_all("o_done", 136, -120, 0, 1, 1, 0);
`endif
    p_valid = 1'b0;
    tick(); tick();
`ifdef BOOTH_ACC_SAT_EN
    chk_all("o_idle", 136, 63, 0, 0, 0, 1);
`else
    chk_all("o_idle", 136, -120, 0, 0, 0, 0);
`endif

    // Next accepted START clears ACC and the overflow flag
    start = 1'b1; len = 4'd1;
    tick();
    start = 1'b0;
    chk_all("n_start", 0, 0, 1, 1, 0, 0);
    p_valid = 1'b1; product = 8'd1;
    tick();
    p_valid = 1'b0;
    chk_all("n_done", 1, 1, 0, 1, 1, 0);
    tick();
    chk_all("n_idle", 1, 1, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
